// File: rtl/apb_uart_tx.sv
// APB-programmable UART transmitter with a small TX FIFO and DMA request.
// Register writes land on the edge that ends the access phase; PREADY is tied
// high; each frame is 1 start, 8 data (LSB first), 1 stop bit of BAUDDIV+1 clocks.
//
// Ports:
//   PCLK, PRESETn           clock / asynchronous reset (asserted when 1)
//   PADDR, PSELx, PENABLE,  APB slave request
//   PWRITE, PWDATA
//   PRDATA, PREADY, PSLVERR APB slave response
//   tx                      serial output, idle high
//   dma_tx_req              registered request: DMA enabled and FIFO not full
module apb_uart_tx #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] BAUD_RST   = 8'h0F
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic [3:0] PADDR,
  input  logic       PSELx,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR,
  output logic       tx,
  output logic       dma_tx_req
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [7:0]  mem_d [FIFO_DEPTH];
  logic [7:0]  baud_q, baud_d;
  logic        tx_en_q, tx_en_d, dma_en_q, dma_en_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  div_q, div_d;     // BAUDDIV captured at frame start
  logic [7:0]  cnt_q, cnt_d;     // clocks elapsed within the current bit
  logic [2:0]  bit_q, bit_d;
  logic        dma_req_q, dma_req_d;

  logic        access, addr_ok, err, wr_ok, full, empty, busy, bit_end;
  logic [1:0]  reg_sel;
  logic [AW:0] level;
  logic [4:0]  level_x;
  logic [2:0]  level_sat;
  logic [7:0]  status;

  assign access  = PSELx & PENABLE;
  assign addr_ok = (PADDR[1:0] == 2'b00);
  assign reg_sel = PADDR[3:2];

  // Extra pointer MSB separates full (MSBs differ) from empty (equal).
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign level = wr_ptr_q - rd_ptr_q;
  assign level_x   = 5'(level);
  assign level_sat = (level_x > 5'd7) ? 3'd7 : level_x[2:0];
  assign busy   = (state_q != IDLE);
  assign status = {2'b00, level_sat, busy, empty, full};

  // full is the pre-edge value, so a same-cycle pop never rescues a push.
  assign err   = access & (!addr_ok |
                           (PWRITE & (reg_sel == 2'd1)) |
                           (PWRITE & (reg_sel == 2'd0) & full));
  assign wr_ok = access & PWRITE & !err;

  assign PREADY     = 1'b1;
  assign PSLVERR    = err & !PRESETn;
  assign dma_tx_req = dma_req_q;
  assign bit_end    = (cnt_q == div_q);

  always_comb begin
    PRDATA = 8'h00;
    if (PSELx && !PWRITE && addr_ok && !PRESETn) begin
      case (reg_sel)
        2'd1:    PRDATA = status;
        2'd2:    PRDATA = baud_q;
        2'd3:    PRDATA = {6'b0, dma_en_q, tx_en_q};
        default: PRDATA = 8'h00;
      endcase
    end
  end

  // tx is decoded from state so reset forces it high without waiting for a clock.
  always_comb begin
    case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = shift_q[0];
      default: tx = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    mem_d     = mem_q;
    baud_d    = baud_q;
    tx_en_d   = tx_en_q;
    dma_en_d  = dma_en_q;
    shift_d   = shift_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    dma_req_d = dma_en_q & !full;

    if (wr_ok) begin
      case (reg_sel)
        2'd0: begin
          mem_d[wr_ptr_q[AW-1:0]] = PWDATA;
          wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        2'd2:    baud_d = PWDATA;
        2'd3: begin
          tx_en_d  = PWDATA[0];
          dma_en_d = PWDATA[1];
        end
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (tx_en_q && !empty) begin
          shift_d  = mem_q[rd_ptr_q[AW-1:0]];
          rd_ptr_d = rd_ptr_q + (AW+1)'(1);
          div_d    = baud_q;
          cnt_d    = 8'd0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = 8'd0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = 8'd0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      baud_q    <= BAUD_RST;
      tx_en_q   <= 1'b0;
      dma_en_q  <= 1'b0;
      shift_q   <= 8'h00;
      div_q     <= 8'h00;
      cnt_q     <= 8'h00;
      bit_q     <= 3'd0;
      dma_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      mem_q     <= mem_d;
      baud_q    <= baud_d;
      tx_en_q   <= tx_en_d;
      dma_en_q  <= dma_en_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      dma_req_q <= dma_req_d;
    end
  end

endmodule

// File: tb/tb_apb_uart_tx.sv
// Testbench for apb_uart_tx: APB register accesses plus a serial-line monitor
// that decodes frames and compares them against bytes queued when written.
// Ports: drives all APB inputs, observes PRDATA/PSLVERR/PREADY/tx/dma_tx_req.
module tb_apb_uart_tx;

  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b1;
  logic [3:0] PADDR = 4'h0;
  logic       PSELx = 1'b0;
  logic       PENABLE = 1'b0;
  logic       PWRITE = 1'b0;
  logic [7:0] PWDATA = 8'h00;
  logic [7:0] PRDATA;
  logic       PREADY, PSLVERR, tx, dma_tx_req;

  int         n_pass = 0;
  int         n_total = 0;
  int         frames_rx = 0;
  int         cur_div = 15;
  bit         mon_en = 1'b1;
  logic [7:0] sb_q[$];

  apb_uart_tx #(.FIFO_DEPTH(4), .BAUD_RST(8'h0F)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSELx(PSELx),
    .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .tx(tx), .dma_tx_req(dma_tx_req)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_total++;
    if (got === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp_v);
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [7:0] d, output logic err);
    @(posedge PCLK); #1;
    PADDR = a; PWDATA = d; PWRITE = 1'b1; PSELx = 1'b1; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    err = PSLVERR;
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [7:0] d, output logic err);
    @(posedge PCLK); #1;
    PADDR = a; PWRITE = 1'b0; PSELx = 1'b1; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    d = PRDATA; err = PSLVERR;
    @(posedge PCLK); #1;
    PSELx = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wr_chk(input string tag, input logic [3:0] a, input logic [7:0] d,
                        input logic exp_err);
    logic e;
    apb_write(a, d, e);
    check(tag, e, exp_err);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [7:0] exp_d);
    logic [7:0] d;
    logic e;
    apb_read(a, d, e);
    check(tag, d, exp_d);
  endtask

  // Byte writes to TXDATA that are expected to be transmitted.
  task automatic send_byte(input string tag, input logic [7:0] d);
    sb_q.push_back(d);
    wr_chk(tag, 4'h0, d, 1'b0);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (frames_rx < n && c < budget) begin
      @(posedge PCLK);
      c++;
    end
    check("frames_received", frames_rx, n);
  endtask

  // Samples every cycle of a frame: each bit must hold its value for div+1 clocks.
  task automatic rx_frame();
    logic [7:0] rx_b, exp_b;
    int div;
    int glitch;
    div = cur_div;
    glitch = 0;
    rx_b = 8'h00;
    for (int c = 1; c <= div; c++) begin
      @(negedge PCLK);
      if (tx !== 1'b0) glitch++;
    end
    for (int b = 0; b < 8; b++) begin
      @(negedge PCLK);
      rx_b[b] = tx;
      for (int c = 1; c <= div; c++) begin
        @(negedge PCLK);
        if (tx !== rx_b[b]) glitch++;
      end
    end
    for (int c = 0; c <= div; c++) begin
      @(negedge PCLK);
      if (tx !== 1'b1) glitch++;
    end
    check("frame_timing", glitch, 0);
    check("sb_has_entry", (sb_q.size() > 0), 1);
    exp_b = (sb_q.size() > 0) ? sb_q.pop_front() : 8'hxx;
    check("frame_data", rx_b, exp_b);
    @(negedge PCLK);
    check("idle_gap", tx, 1'b1);
    frames_rx++;
  endtask

  initial begin
    forever begin
      @(negedge PCLK);
      if (mon_en && !PRESETn && tx === 1'b0) rx_frame();
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    // Reset state
    #1;
    check("rst_tx", tx, 1'b1);
    check("rst_pslverr", PSLVERR, 1'b0);
    check("rst_prdata", PRDATA, 8'h00);
    check("rst_dma", dma_tx_req, 1'b0);
    check("pready", PREADY, 1'b1);
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b0;
    rd_chk("rst_status", 4'h4, 8'h02);
    rd_chk("rst_baud", 4'h8, 8'h0F);
    rd_chk("rst_ctrl", 4'hC, 8'h00);

    // Single frame 0xA5 at BAUDDIV=3
    cur_div = 3;
    wr_chk("wr_baud", 4'h8, 8'h03, 1'b0);
    rd_chk("rd_baud", 4'h8, 8'h03);
    wr_chk("wr_ctrl_en", 4'hC, 8'h01, 1'b0);
    send_byte("wr_a5", 8'hA5);
    rd_chk("status_busy", 4'h4, 8'h06);
    wait_frames(1, 200);
    rd_chk("status_after_a5", 4'h4, 8'h02);

    // Fill FIFO with tx disabled, overflow, then drain in order
    wr_chk("ctrl_off", 4'hC, 8'h00, 1'b0);
    cur_div = 1;
    wr_chk("wr_baud1", 4'h8, 8'h01, 1'b0);
    send_byte("fill0", 8'h01);
    send_byte("fill1", 8'h80);
    send_byte("fill2", 8'hFF);
    send_byte("fill3", 8'h3C);
    wr_chk("overflow_err", 4'h0, 8'hEE, 1'b1);
    rd_chk("status_full", 4'h4, 8'h21);
    wr_chk("ctrl_on", 4'hC, 8'h01, 1'b0);
    send_byte("push_while_tx", 8'h77);
    wait_frames(6, 600);
    rd_chk("status_drained", 4'h4, 8'h02);

    // Erroring accesses change nothing
    wr_chk("status_wr_err", 4'h4, 8'hFF, 1'b1);
    begin
      logic [7:0] d;
      logic e;
      apb_read(4'h3, d, e);
      check("misaligned_rd_err", e, 1'b1);
      check("misaligned_rd_data", d, 8'h00);
      apb_read(4'h0, d, e);
      check("txdata_rd_err", e, 1'b0);
      check("txdata_rd_data", d, 8'h00);
    end
    wr_chk("misaligned_wr_err", 4'h9, 8'h55, 1'b1);
    rd_chk("baud_unchanged", 4'h8, 8'h01);
    rd_chk("status_unchanged", 4'h4, 8'h02);

    // DMA request tracking
    wr_chk("ctrl_dma", 4'hC, 8'h02, 1'b0);
    check("dma_same_edge", dma_tx_req, 1'b0);
    @(posedge PCLK); #1;
    check("dma_next_clk", dma_tx_req, 1'b1);
    send_byte("dma_fill0", 8'h11);
    send_byte("dma_fill1", 8'h22);
    send_byte("dma_fill2", 8'h33);
    send_byte("dma_fill3", 8'h44);
    check("dma_at_full_edge", dma_tx_req, 1'b1);
    @(posedge PCLK); #1;
    check("dma_full", dma_tx_req, 1'b0);
    rd_chk("status_dma_full", 4'h4, 8'h21);
    wr_chk("ctrl_dma_en", 4'hC, 8'h03, 1'b0);
    wait_frames(10, 600);
    check("dma_after_drain", dma_tx_req, 1'b1);

    // Clearing tx_en mid-frame finishes the frame, then holds
    cur_div = 3;
    wr_chk("ctrl_off2", 4'hC, 8'h00, 1'b0);
    wr_chk("wr_baud3", 4'h8, 8'h03, 1'b0);
    send_byte("hold0", 8'hC3);
    send_byte("hold1", 8'h5A);
    wr_chk("ctrl_on2", 4'hC, 8'h01, 1'b0);
    repeat (15) @(posedge PCLK);
    wr_chk("ctrl_clear_mid", 4'hC, 8'h00, 1'b0);
    wait_frames(11, 200);
    n0 = frames_rx;
    repeat (20) @(posedge PCLK);
    check("no_frame_when_off", frames_rx, n0);
    rd_chk("status_held", 4'h4, 8'h08);
    wr_chk("ctrl_on3", 4'hC, 8'h01, 1'b0);
    wait_frames(12, 200);

    // Reset mid-frame
    mon_en = 1'b0;
    wr_chk("wr_rst_frame", 4'h0, 8'h3C, 1'b0);
    repeat (6) @(posedge PCLK);
    #3;
    check("pre_reset_tx", tx, 1'b0);
    PRESETn = 1'b1;
    #1;
    check("reset_tx_async", tx, 1'b1);
    check("reset_dma", dma_tx_req, 1'b0);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b0;
    rd_chk("post_rst_status", 4'h4, 8'h02);
    rd_chk("post_rst_baud", 4'h8, 8'h0F);
    rd_chk("post_rst_ctrl", 4'hC, 8'h00);
    mon_en = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
